period_gen: RTL

PERIOD_GEN -- requirements
Module: period_gen

---
 rtl/period_gen_if.sv | 32 +++
 rtl/period_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/period_gen_if.sv
// ============================================================================
// period_gen_if: configuration handshake bundle for period_gen.  Rev 1.0
// ============================================================================
`default_nettype none

interface period_gen_if #(
    parameter int W = 16
);
    logic         cfg_valid;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         cfg_ready;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_high,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_high,
        output cfg_ready,
        output cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/period_gen.sv
// ============================================================================
// period_gen: programmable period/high-time clock generator with lock detect. Rev 1.0
// ============================================================================
`default_nettype none

module period_gen #(
    parameter int W            = 16,
    parameter int LOCK_PERIODS = 2
) (
    input  wire logic        clk,
    input  wire logic        RST,
    input  wire logic        PWRDWN,
    period_gen_if.slave      cfg,
    output logic             clk_out,
    output logic             period_start,
    output logic             locked
);

    localparam int            LW        = (LOCK_PERIODS > 1) ? $clog2(LOCK_PERIODS) : 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_PERIODS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          clk_out_q, clk_out_d;
    logic          ps_q, ps_d;
    logic          locked_q, locked_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          cfg_err_q, cfg_err_d;
    logic [W-1:0]  act_period_q, act_period_d;
    logic [W-1:0]  act_high_q, act_high_d;
    logic          pend_valid_q, pend_valid_d;
    logic [W-1:0]  pend_period_q, pend_period_d;
    logic [W-1:0]  pend_high_q, pend_high_d;

    logic w_xfer, w_legal, w_apply, w_start;

    assign w_xfer  = cfg.cfg_valid && !pend_valid_q;
    assign w_legal = (cfg.cfg_period >= W'(2)) && (cfg.cfg_high != '0) &&
                     (cfg.cfg_high < cfg.cfg_period);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        clk_out_d     = clk_out_q;
        ps_d          = 1'b0;
        locked_d      = locked_q;
        lock_cnt_d    = lock_cnt_q;
        cfg_err_d     = 1'b0;
        act_period_d  = act_period_q;
        act_high_d    = act_high_q;
        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        w_apply       = 1'b0;
        w_start       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_valid_q && !PWRDWN) begin
                    w_apply = 1'b1;
                    w_start = 1'b1;
                end
            end
            S_RUN: begin
                if (PWRDWN) begin
                    state_d   = S_HALT;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    locked_d  = 1'b0;
                end else if (cnt_q == act_period_q - W'(1)) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                    ps_d      = 1'b1;
                    if (pend_valid_q) begin
                        w_apply = 1'b1;
                    end else if (!locked_q) begin
                        // lock_cnt holds completed periods; this wrap completes one more
                        if (lock_cnt_q == LOCK_LAST) begin
                            locked_d = 1'b1;
                        end else begin
                            lock_cnt_d = lock_cnt_q + LW'(1);
                        end
                    end
                end else begin
                    cnt_d     = cnt_q + W'(1);
                    clk_out_d = (cnt_q + W'(1)) < act_high_q;
                end
            end
            S_HALT: begin
                w_apply = pend_valid_q;
                w_start = !PWRDWN;
            end
            default: state_d = S_IDLE;
        endcase

        if (w_start) begin
            state_d    = S_RUN;
            cnt_d      = '0;
            clk_out_d  = 1'b1;
            ps_d       = 1'b1;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
        end

        if (w_apply) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            pend_valid_d = 1'b0;
            locked_d     = 1'b0;
            lock_cnt_d   = '0;
        end

        // Apply and transfer never coincide: a transfer needs the pending slot empty
        if (w_xfer) begin
            if (w_legal) begin
                pend_valid_d  = 1'b1;
                pend_period_d = cfg.cfg_period;
                pend_high_d   = cfg.cfg_high;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            clk_out_q     <= 1'b0;
            ps_q          <= 1'b0;
            locked_q      <= 1'b0;
            lock_cnt_q    <= '0;
            cfg_err_q     <= 1'b0;
            act_period_q  <= '0;
            act_high_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            pend_high_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            clk_out_q     <= clk_out_d;
            ps_q          <= ps_d;
            locked_q      <= locked_d;
            lock_cnt_q    <= lock_cnt_d;
            cfg_err_q     <= cfg_err_d;
            act_period_q  <= act_period_d;
            act_high_q    <= act_high_d;
            pend_valid_q  <= pend_valid_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
        end
    end

    assign clk_out       = clk_out_q;
    assign period_start  = ps_q;
    assign locked        = locked_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign cfg.cfg_ready = !pend_valid_q;

endmodule

`default_nettype wire
